// File: rtl/brq_param.sv
// Parametrised bus request queue: N_REQ requesters arbitrated (fixed or round-robin)
// into a DEPTH-entry FIFO whose head is offered only when its destination is free.
module brq_param #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned N_DEST = 5,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned RR     = 0,
  localparam int unsigned DW    = (N_DEST > 1) ? $clog2(N_DEST) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_REQ*ID_W-1:0]  send_in,
  input  logic [N_REQ*DW-1:0]    dest_in,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       ack,
  input  logic [N_DEST-1:0]      free,
  input  logic                   pull,
  output logic                   valid,
  output logic                   empty,
  output logic                   full,
  output logic [CW-1:0]          count,
  output logic [ID_W-1:0]        send_out,
  output logic [DW-1:0]          dest_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(N_REQ);
  localparam int unsigned EW = ID_W + DW;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [LW-1:0]   last_q;

  logic [EW-1:0]   head;
  logic            head_free;
  logic            pop, enq_ok, gnt, found;
  logic [LW-1:0]   gnt_idx, idx;
  logic [ID_W-1:0] wr_send;
  logic [DW-1:0]   wr_dest;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Head and status decode; count_q is cleared asynchronously so outputs drop at once.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    count    = count_q;
    send_out = empty ? '0 : head[EW-1:DW];
    dest_out = empty ? '0 : head[DW-1:0];
  end

  // Destinations with no free bit behind them count as always free.
  always_comb begin
    head_free = 1'b1;
    for (int i = 0; i < int'(N_DEST); i++) begin
      if (dest_out == DW'(i)) head_free = free[i];
    end
  end

  assign valid  = ~empty & head_free;
  assign pop    = pull & valid;
  assign enq_ok = ~full | pop;

  always_comb begin
    ack     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    if (!clr && enq_ok) begin
      if (RR == 0) begin
        for (int i = 0; i < int'(N_REQ); i++) begin
          if (req[i]) begin
            gnt_idx = LW'(i);
            found   = 1'b1;
          end
        end
      end else begin
        for (int k = 1; k <= int'(N_REQ); k++) begin
          idx = LW'((int'(last_q) + k) % int'(N_REQ));
          if (!found && req[idx]) begin
            gnt_idx = idx;
            found   = 1'b1;
          end
        end
      end
      if (found) ack[gnt_idx] = 1'b1;
    end
  end

  assign gnt = |ack;

  always_comb begin
    wr_send = '0;
    wr_dest = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_idx == LW'(i)) begin
        wr_send = send_in[i*ID_W +: ID_W];
        wr_dest = dest_in[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) mem_q[wr_ptr_q] <= {wr_send, wr_dest};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= LW'(N_REQ - 1);
    end else begin
      if (gnt) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        last_q   <= gnt_idx;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (gnt && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !gnt) count_q <= count_q - CW'(1);
    end
  end

endmodule
